// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// display_arbiter
//   Shares the 7-digit parking display (28-bit packed nibble code, digit 0 in
//   bits [3:0]) between the default occupancy code and two gate message
//   requesters. Gate messages are granted round-robin, held on the display
//   for HOLD_CYCLES cycles, after which the display reverts to def_code.
//   Nibble 4'hA renders as a dash, so 28'hAAAAAAA shows all dashes.
//
//   Optional feature macro: DISP_BLINK_EN
//     When defined, a held message blinks: it alternates between the message
//     and all-dashes every BLINK_CYCLES cycles, starting with the message on
//     the grant edge. When undefined, the message is shown steadily.
//
// Parameters
//   HOLD_CYCLES   cycles a granted message stays on the display (>= 1)
//   BLINK_CYCLES  blink half-period, used only with DISP_BLINK_EN (>= 1)
//
// Ports
//   CLK       in   1   system clock, rising edge
//   RST       in   1   asynchronous active-high reset
//   def_code  in  28   default display code, sampled every idle cycle
//   req       in   2   level requests: bit 0 entry gate, bit 1 exit gate
//   msg0      in  28   entry message, stable while req[0] is high
//   msg1      in  28   exit message, stable while req[1] is high
//   ack       out  2   one-cycle grant pulse, message captured on same edge
//   code      out 28   registered code to the 7-segment decoder bank
//   busy      out  1   high while a message is held
//   owner     out  2   one-hot current owner, 2'b00 when showing def_code
// ---------------------------------------------------------------------------
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [27:0] def_code,
  input  logic [1:0]  req,
  input  logic [27:0] msg0,
  input  logic [27:0] msg1,
  output logic [1:0]  ack,
  output logic [27:0] code,
  output logic        busy,
  output logic [1:0]  owner
);

  localparam int unsigned CNT_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [27:0] DASHES = 28'hAAAAAAA;
  localparam bit CFG_OK = (HOLD_CYCLES >= 1) && (BLINK_CYCLES >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("display_arbiter: HOLD_CYCLES and BLINK_CYCLES must be >= 1");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  // Last granted requester; reset to 1 so that req[0] wins the first tie.
  logic             r_last, w_last_nxt;
  logic [1:0]       r_ack, w_ack_nxt;
  logic [1:0]       r_owner, w_owner_nxt;
  logic             r_busy, w_busy_nxt;
  logic [27:0]      r_code, w_code_nxt;
  logic [27:0]      r_msg;

  logic             w_tc;
  logic             w_arb;
  logic [1:0]       w_gnt;
  logic [27:0]      w_msg_sel;
  logic [27:0]      w_hold_code;

  // Arbitration happens in IDLE and at the terminal count of a hold only;
  // requests raised mid-hold simply wait (no preemption, no pending state).
  always_comb begin
    w_tc  = (r_state == S_HOLD) && (r_cnt == HOLD_TC);
    w_arb = (r_state == S_IDLE) || w_tc;
    w_gnt = 2'b00;
    if (w_arb) begin
      unique case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
    w_msg_sel = w_gnt[1] ? msg1 : msg0;
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned BL_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [BL_W-1:0] BLINK_TC = BL_W'(BLINK_CYCLES - 1);

  logic [BL_W-1:0] r_bl_cnt, w_bl_cnt_nxt;
  logic            r_bl_ph, w_bl_ph_nxt;

  // Phase 0 shows the message, phase 1 shows dashes; both restart on a grant.
  always_comb begin
    w_bl_cnt_nxt = '0;
    w_bl_ph_nxt  = 1'b0;
    if ((w_gnt == 2'b00) && (r_state == S_HOLD)) begin
      if (r_bl_cnt == BLINK_TC) begin
        w_bl_cnt_nxt = '0;
        w_bl_ph_nxt  = ~r_bl_ph;
      end else begin
        w_bl_cnt_nxt = r_bl_cnt + BL_W'(1);
        w_bl_ph_nxt  = r_bl_ph;
      end
    end
    w_hold_code = w_bl_ph_nxt ? DASHES : r_msg;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bl_cnt <= '0;
      r_bl_ph  <= 1'b0;
    end else begin
      r_bl_cnt <= w_bl_cnt_nxt;
      r_bl_ph  <= w_bl_ph_nxt;
    end
  end
`else
  always_comb begin
    w_hold_code = r_msg;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_ack_nxt   = 2'b00;
    w_owner_nxt = r_owner;
    w_busy_nxt  = r_busy;
    w_code_nxt  = r_code;
    if (w_gnt != 2'b00) begin
      // New grant: message goes straight to the display on this edge.
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_last_nxt  = w_gnt[1];
      w_ack_nxt   = w_gnt;
      w_owner_nxt = w_gnt;
      w_busy_nxt  = 1'b1;
      w_code_nxt  = w_msg_sel;
    end else if (w_arb) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_owner_nxt = 2'b00;
      w_busy_nxt  = 1'b0;
      w_code_nxt  = def_code;
    end else begin
      w_cnt_nxt  = r_cnt + CNT_W'(1);
      w_code_nxt = w_hold_code;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_ack   <= 2'b00;
      r_owner <= 2'b00;
      r_busy  <= 1'b0;
      r_code  <= DASHES;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_ack   <= w_ack_nxt;
      r_owner <= w_owner_nxt;
      r_busy  <= w_busy_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // Captured message copy; only meaningful while in HOLD.
  always_ff @(posedge CLK) begin
    if (w_gnt != 2'b00) begin
      r_msg <= w_msg_sel;
    end
  end

  assign ack   = r_ack;
  assign code  = r_code;
  assign busy  = r_busy;
  assign owner = r_owner;

endmodule
